// File: rtl/lvds_pkg.sv
// rtl/lvds_pkg.sv - shared LVDS mapper constants, FSM encoding and colour-bar table
package lvds_pkg;

   localparam logic [6:0] CLK_LANE_WORD = 7'b1100011;
   localparam logic [6:0] BLANK_WORD    = 7'b0000000;

   localparam logic [1:0] ST_OFF      = 2'd0;
   localparam logic [1:0] ST_ARMED    = 2'd1;
   localparam logic [1:0] ST_LIVE     = 2'd2;
   localparam logic [1:0] ST_STOPPING = 2'd3;

   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lvds_bit_map.sv
// rtl/lvds_bit_map.sv - combinational VESA/JEIDA mapping of one video beat onto four FPD-Link lane words
module lvds_bit_map
   import lvds_pkg::*;
#(
   parameter int JEIDA = 0
) (
   input  logic [23:0] rgb,
   input  logic        hs,
   input  logic        vs,
   input  logic        de,
   output logic [6:0]  lane0,
   output logic [6:0]  lane1,
   output logic [6:0]  lane2,
   output logic [6:0]  lane3
);

   logic [7:0] r, g, b;
   logic [5:0] r6, g6, b6;
   logic [1:0] r2, g2, b2;

   assign {r, g, b} = rgb;

   // JEIDA puts the MSBs in lanes 0-2 and the two LSBs on lane 3; VESA is the reverse.
   assign r6 = (JEIDA != 0) ? r[7:2] : r[5:0];
   assign g6 = (JEIDA != 0) ? g[7:2] : g[5:0];
   assign b6 = (JEIDA != 0) ? b[7:2] : b[5:0];
   assign r2 = (JEIDA != 0) ? r[1:0] : r[7:6];
   assign g2 = (JEIDA != 0) ? g[1:0] : g[7:6];
   assign b2 = (JEIDA != 0) ? b[1:0] : b[7:6];

   assign lane0 = {g6[0], r6};
   assign lane1 = {b6[1:0], g6[5:1]};
   assign lane2 = {de, vs, hs, b6[5:2]};
   assign lane3 = {1'b0, b2, g2, r2};

endmodule

// File: rtl/lvds_tx_mapper.sv
// rtl/lvds_tx_mapper.sv - two-stage pixel to FPD-Link lane mapper with frame-gated enable; LVDS_TESTPAT_EN adds colour bars
module lvds_tx_mapper
   import lvds_pkg::*;
#(
   parameter int JEIDA  = 0,
   parameter int HS_POL = 1,
   parameter int VS_POL = 1,
   parameter int BAR_W  = 128
) (
   input  logic        pixel_clk,
   input  logic        sys_rst,
   input  logic        enable,
   input  logic [23:0] rgb_in,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        de_in,
   input  logic        test_mode,
   output logic [6:0]  lane0,
   output logic [6:0]  lane1,
   output logic [6:0]  lane2,
   output logic [6:0]  lane3,
   output logic [6:0]  clk_lane,
   output logic        active,
   output logic [15:0] frame_cnt
);

   logic [23:0] rgb_src, rgb_s1;
   logic        hs_s1, vs_s1, de_s1, vs_prev, vs_edge;
   logic [1:0]  state, state_nxt;
   logic        live_nxt;
   logic [6:0]  map0, map1, map2, map3;

`ifdef LVDS_TESTPAT_EN
   logic [15:0] sub_cnt;
   logic [2:0]  bar_idx;

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sub_cnt <= '0;
         bar_idx <= '0;
      end else if (!de_in) begin
         sub_cnt <= '0;
         bar_idx <= '0;
      end else if (sub_cnt == 16'(BAR_W - 1)) begin
         sub_cnt <= '0;
         if (bar_idx != 3'd7)
            bar_idx <= bar_idx + 3'd1;
      end else begin
         sub_cnt <= sub_cnt + 16'd1;
      end
   end

   assign rgb_src = (test_mode && de_in) ? bar_rgb(bar_idx) : rgb_in;
`else
   localparam int unused_bar_w = BAR_W;
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign rgb_src = rgb_in;
`endif

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rgb_s1  <= '0;
         hs_s1   <= 1'b0;
         vs_s1   <= 1'b0;
         de_s1   <= 1'b0;
         vs_prev <= 1'b0;
      end else begin
         rgb_s1  <= rgb_src;
         hs_s1   <= (HS_POL != 0) ? hs_in : ~hs_in;
         vs_s1   <= (VS_POL != 0) ? vs_in : ~vs_in;
         de_s1   <= de_in;
         vs_prev <= vs_s1;
      end
   end

   assign vs_edge = vs_s1 & ~vs_prev;

   // A frame boundary outranks a same-cycle enable change in every state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_OFF:      if (enable) state_nxt = ST_ARMED;
         ST_ARMED:    if (vs_edge) state_nxt = ST_LIVE;
                      else if (!enable) state_nxt = ST_OFF;
         ST_LIVE:     if (!enable) state_nxt = ST_STOPPING;
         ST_STOPPING: if (vs_edge) state_nxt = ST_OFF;
                      else if (enable) state_nxt = ST_LIVE;
      endcase
   end

   assign live_nxt = (state_nxt == ST_LIVE) || (state_nxt == ST_STOPPING);

   lvds_bit_map #(.JEIDA(JEIDA)) u_map (
      .rgb   (rgb_s1),
      .hs    (hs_s1),
      .vs    (vs_s1),
      .de    (de_s1),
      .lane0 (map0),
      .lane1 (map1),
      .lane2 (map2),
      .lane3 (map3)
   );

   // Gating on next-state blanks or opens the boundary beat in its own cycle.
   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= ST_OFF;
         lane0     <= BLANK_WORD;
         lane1     <= BLANK_WORD;
         lane2     <= BLANK_WORD;
         lane3     <= BLANK_WORD;
         active    <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state  <= state_nxt;
         active <= live_nxt;
         lane0  <= live_nxt ? map0 : BLANK_WORD;
         lane1  <= live_nxt ? map1 : BLANK_WORD;
         lane2  <= live_nxt ? map2 : BLANK_WORD;
         lane3  <= live_nxt ? map3 : BLANK_WORD;
         if (vs_edge && (state == ST_ARMED || state == ST_LIVE))
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

   assign clk_lane = CLK_LANE_WORD;

endmodule

// File: tb/tb_lvds_tx_mapper.sv
// tb/tb_lvds_tx_mapper.sv - directed bench for lvds_tx_mapper: VESA, JEIDA, HS_POL=0 and LVDS_TESTPAT_EN bars
module tb_lvds_tx_mapper;

   logic        pixel_clk = 1'b0;
   logic        sys_rst, enable, hs, hs_n, vs, de, tm, tm0;
   logic [23:0] rgb;

   logic [6:0]  v_l0, v_l1, v_l2, v_l3, v_ck;
   logic        v_act;
   logic [15:0] v_fc;
   logic [6:0]  j_l0, j_l1, j_l2, j_l3, j_ck;
   logic        j_act;
   logic [15:0] j_fc;
   logic [6:0]  n_l0, n_l1, n_l2, n_l3, n_ck;
   logic        n_act;
   logic [15:0] n_fc;

   int checks = 0;
   int errors = 0;

   always #5 pixel_clk = ~pixel_clk;

   lvds_tx_mapper u_vesa (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .enable(enable), .rgb_in(rgb),
      .hs_in(hs), .vs_in(vs), .de_in(de), .test_mode(tm0),
      .lane0(v_l0), .lane1(v_l1), .lane2(v_l2), .lane3(v_l3),
      .clk_lane(v_ck), .active(v_act), .frame_cnt(v_fc)
   );

   lvds_tx_mapper #(.JEIDA(1)) u_jeida (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .enable(enable), .rgb_in(rgb),
      .hs_in(hs), .vs_in(vs), .de_in(de), .test_mode(tm0),
      .lane0(j_l0), .lane1(j_l1), .lane2(j_l2), .lane3(j_l3),
      .clk_lane(j_ck), .active(j_act), .frame_cnt(j_fc)
   );

   lvds_tx_mapper #(.HS_POL(0)) u_hsn (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .enable(enable), .rgb_in(rgb),
      .hs_in(hs_n), .vs_in(vs), .de_in(de), .test_mode(tm0),
      .lane0(n_l0), .lane1(n_l1), .lane2(n_l2), .lane3(n_l3),
      .clk_lane(n_ck), .active(n_act), .frame_cnt(n_fc)
   );

`ifdef LVDS_TESTPAT_EN
   logic [6:0]  t_l0, t_l1, t_l2, t_l3, t_ck;
   logic        t_act;
   logic [15:0] t_fc;

   lvds_tx_mapper #(.BAR_W(4)) u_tp (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .enable(enable), .rgb_in(rgb),
      .hs_in(hs), .vs_in(vs), .de_in(de), .test_mode(tm),
      .lane0(t_l0), .lane1(t_l1), .lane2(t_l2), .lane3(t_l3),
      .clk_lane(t_ck), .active(t_act), .frame_cnt(t_fc)
   );

   function automatic logic [23:0] vesa_unmap(input logic [6:0] l0, l1, l2, l3);
      logic [7:0] r, g, b;
      r = {l3[1:0], l0[5:0]};
      g = {l3[3:2], l1[4:0], l0[6]};
      b = {l3[5:4], l2[3:0], l1[6:5]};
      return {r, g, b};
   endfunction

   function automatic logic [23:0] bar_exp(input int p);
      int idx;
      idx = (p / 4 > 7) ? 7 : p / 4;
      case (idx)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v);
      vs = v;
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic frame(input int n);
      drive(1'b1);
      repeat (n) drive(1'b0);
   endtask

   initial begin
      sys_rst = 1'b1; enable = 1'b0; hs = 1'b0; hs_n = 1'b1; vs = 1'b0;
      de = 1'b1; rgb = 24'hFF0000; tm = 1'b0; tm0 = 1'b0;
      repeat (2) @(posedge pixel_clk);
      #1;
      chk("rst_lane0", 32'(v_l0), 32'(7'b0000000));
      chk("rst_lane2", 32'(v_l2), 32'(7'b0000000));
      chk("rst_clk_lane", 32'(v_ck), 32'(7'b1100011));
      chk("rst_active", 32'(v_act), 32'(1'b0));
      chk("rst_frame_cnt", 32'(v_fc), 32'(16'd0));
      sys_rst = 1'b0;

      frame(4);
      frame(4);
      chk("off_lane0", 32'(v_l0), 32'(7'b0000000));
      chk("off_lane3", 32'(v_l3), 32'(7'b0000000));
      chk("off_active", 32'(v_act), 32'(1'b0));
      chk("off_frame_cnt", 32'(v_fc), 32'(16'd0));
      chk("off_clk_lane", 32'(v_ck), 32'(7'b1100011));

      // enable mid-frame: ARMED stays blank until the next vs edge reaches S2
      enable = 1'b1;
      drive(1'b0);
      drive(1'b0);
      chk("armed_lane0", 32'(v_l0), 32'(7'b0000000));
      chk("armed_active", 32'(v_act), 32'(1'b0));
      drive(1'b1);
      chk("pre_edge_active", 32'(v_act), 32'(1'b0));
      drive(1'b0);
      chk("live_active", 32'(v_act), 32'(1'b1));
      chk("live_lane0", 32'(v_l0), 32'(7'b0111111));
      chk("live_lane2", 32'(v_l2), 32'(7'b1100000));
      chk("live_lane3", 32'(v_l3), 32'(7'b0000011));
      chk("live_frame_cnt", 32'(v_fc), 32'(16'd1));
      chk("jeida_ff_lane0", 32'(j_l0), 32'(7'b0111111));
      chk("jeida_ff_lane3", 32'(j_l3), 32'(7'b0000011));
      chk("hspol0_idle_lane2", 32'(n_l2), 32'(7'b1100000));

      hs = 1'b1; hs_n = 1'b0;
      drive(1'b0);
      hs = 1'b0; hs_n = 1'b1;
      drive(1'b0);
      chk("vesa_hs_lane2", 32'(v_l2), 32'(7'b1010000));
      chk("hspol0_hs_lane2", 32'(n_l2), 32'(7'b1010000));

      rgb = 24'h030303;
      drive(1'b0);
      rgb = 24'hFF0000;
      drive(1'b0);
      chk("jeida_030303_lane0", 32'(j_l0), 32'(7'b0000000));
      chk("jeida_030303_lane3", 32'(j_l3), 32'(7'b0111111));
      chk("vesa_030303_lane0", 32'(v_l0), 32'(7'b1000011));
      chk("vesa_030303_lane1", 32'(v_l1), 32'(7'b1100001));

      frame(3);
      chk("frame2_cnt", 32'(v_fc), 32'(16'd2));

      // frame 3, enable dropped mid-frame: rest of frame still goes out
      drive(1'b1);
      drive(1'b0);
      drive(1'b0);
      enable = 1'b0;
      drive(1'b0);
      drive(1'b0);
      drive(1'b0);
      chk("stopping_active", 32'(v_act), 32'(1'b1));
      chk("stopping_lane0", 32'(v_l0), 32'(7'b0111111));
      chk("stopping_frame_cnt", 32'(v_fc), 32'(16'd3));
      drive(1'b1);
      chk("last_pixel_active", 32'(v_act), 32'(1'b1));
      drive(1'b0);
      chk("exit_active", 32'(v_act), 32'(1'b0));
      chk("exit_lane0", 32'(v_l0), 32'(7'b0000000));
      chk("exit_lane2", 32'(v_l2), 32'(7'b0000000));
      chk("exit_frame_cnt", 32'(v_fc), 32'(16'd3));
      drive(1'b0);
      chk("off_again_lane0", 32'(v_l0), 32'(7'b0000000));

      enable = 1'b1;
      frame(3);
      chk("relive_active", 32'(v_act), 32'(1'b1));
      chk("relive_frame_cnt", 32'(v_fc), 32'(16'd4));

      // asynchronous reset mid-frame
      #3 sys_rst = 1'b1;
      #1;
      chk("async_rst_active", 32'(v_act), 32'(1'b0));
      chk("async_rst_lane0", 32'(v_l0), 32'(7'b0000000));
      chk("async_rst_frame_cnt", 32'(v_fc), 32'(16'd0));
      @(posedge pixel_clk);
      #1;
      sys_rst = 1'b0;

`ifdef LVDS_TESTPAT_EN
      tm = 1'b1; de = 1'b0; rgb = 24'h123456; enable = 1'b1;
      drive(1'b0);
      drive(1'b1);
      drive(1'b0);
      drive(1'b0);
      de = 1'b1;
      for (int k = 0; k <= 32; k++) begin
         drive(1'b0);
         if (k == 1 || k == 4 || k == 5 || k == 8 || k == 9 || k == 28 || k == 29 || k == 32)
            chk($sformatf("bar_px%0d", k - 1), 32'(vesa_unmap(t_l0, t_l1, t_l2, t_l3)), 32'(bar_exp(k - 1)));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
